memory_arbiter: RTL
===================

# memory_arbiter

Two-port arbiter that shares the single `memory_controller` between the CPU datapath and the front-panel/DMA port. Accepts level requests from each side and grants them fairly (round-robin). It issues exactly one single-cycle enable to the memory controller per grant, waits for `operation_done`, then returns read data with a one-cycle `done` pulse to the granted requester. Sits between the CPU/panel logic and `memory_controller`, replacing direct CPU wiring.

## Interface
- `TIMEOUT_CYCLES`, 16 — maximum WAIT cycles before the transaction is aborted with an error.
- `clk  in  1` — system clock, all state on the rising edge.
- `rst_n  in  1` — reset, asynchronous, active-low.
- `cpu_req  in  1` — CPU request, level; held until `cpu_done`.
- `cpu_we  in  1` — 1 = write, 0 = read.
- `cpu_read_type  in  1` — `DATA_READ`/`INSTR_READ`, passed to the controller on reads.
- `cpu_addr  in  word` — 12-bit address.
- `cpu_wdata  in  word` — write data.
- `cpu_rdata  out  word` — read data, valid while `cpu_done`=1.
- `cpu_done  out  1` — one-cycle completion pulse.
- `cpu_err  out  1` — qualifies `cpu_done`: timeout occurred.
- `pnl_req`, `pnl_we`, `pnl_read_type`, `pnl_addr`, `pnl_wdata`, `pnl_rdata`, `pnl_done`, `pnl_err` — identical port set for the front-panel/DMA side.
- `mem_address  out  word` — to the controller's `address`.
- `mem_write_data  out  word` — to `write_data`.
- `mem_read_enable  out  1` — to `read_enable`; single-cycle pulse.
- `mem_write_enable  out  1` — to `write_enable`; single-cycle pulse.
- `mem_read_type  out  1` — to `read_type`.
- `mem_read_data  in  word` — from `read_data`.
- `mem_operation_done  in  1` — from `operation_done`.
- `busy  out  1` — high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- IDLE: if any request is present, select the winner, latch its `we`, `read_type`, `addr` and `wdata` into the mem_* registers, record `grant`, and go to ISSUE.
- ISSUE: assert exactly one of `mem_read_enable` or `mem_write_enable` for this cycle, then go to WAIT.
- WAIT: sample `mem_operation_done`. When it is 1, capture `mem_read_data` into the granted side's rdata register and go to RESPOND. If the WAIT count reaches `TIMEOUT_CYCLES`, set err and go to RESPOND.
- RESPOND: the granted `*_done` is 1 for this cycle, and `*_err` is 1 on timeout. Then go to IDLE.
- Arbitration:
  - Round-robin on `last_grant`, which is updated in IDLE on each grant.
  - With both requests present, the side not in `last_grant` wins.
  - `last_grant` resets to PNL, so the CPU wins the first tie.
- Requester rule: the requester must drop `req` at the edge that ends its `done` cycle. Otherwise the request is re-served as a new transaction.
- Ungranted requests wait with no loss. Their `addr`/`wdata` may change freely until granted; after grant the latched copy is used.
- Writes:
  - `*_rdata` is unchanged.
  - `done` is still pulsed.
  - `mem_read_type` holds its prior value.
- A request that arrives during a non-IDLE state is considered at the next IDLE.

## Timing
- Reset values:
  - all outputs 0; `mem_address`/`mem_write_data`/rdata = 12'o0
  - FSM IDLE, `last_grant` = PNL, timeout counter 0
- Reset mid-transaction: the transaction is abandoned immediately, with no `done` pulse and no enable re-issue.
- Registered outputs:
  - all outputs are registered
  - `busy` is decoded from the state register
- Request sampled high in cycle N (IDLE) → enable high in cycle N+1 (ISSUE) → WAIT from N+2.
- `done` is seen in WAIT cycle M → RESPOND (`done`=1) in cycle M+1 → IDLE in cycle M+2.
- Minimum request-to-done latency is 3 cycles plus the controller latency.
- Back-to-back: a second pending request is granted in the IDLE cycle after RESPOND, so enables are at least 4 cycles apart.
- `mem_operation_done` is ignored outside WAIT.
- Timeout counter:
  - clears on entry to WAIT
  - counts each WAIT cycle without `done`
  - `done` and the terminal count in the same cycle → success, no err.
- `mem_address`, `mem_write_data` and `mem_read_type` stay stable from ISSUE through RESPOND.

## Structure
- Shared package `memory_utils`: `word`, `DATA_READ`/`INSTR_READ`. Add `arb_state_t` (enum IDLE/ISSUE/WAIT/RESPOND) and `requester_t` (CPU, PNL) there.
- Natural sub-module: `rr_arbiter2` (two requests in; grant and `last_grant` update out; purely the winner selection).

## Test plan
- Reset then single CPU write 12'o200←12'o333, then CPU DATA_READ 12'o200 → `mem_write_enable` 1 cycle, then `cpu_done` with `cpu_rdata`=12'o333 and `pnl_done` never asserted.
- CPU and PNL request in the same cycle right after reset → CPU granted first, PNL second. Repeat simultaneously → PNL first, then CPU (alternation).
- PNL read held while the CPU issues 4 back-to-back reads → PNL is served after at most one CPU transaction; no starvation.
- Controller held without `operation_done` (stub) → `cpu_done`=`cpu_err`=1 exactly `TIMEOUT_CYCLES`+1 cycles after ISSUE; next request proceeds normally.
- `rst_n` asserted in WAIT → all outputs 0 asynchronously, no `done`. After release, the retried request completes correctly.
- Write/read sweep of all 4096 addresses, alternating the CPU and PNL ports, data = address → every read matches, and each transaction produces exactly one enable pulse.

Source files
------------

// File: rtl/memory_utils_pkg.sv
// Shared memory-path types: word width, read-type codes and arbiter enums.
package memory_utils;

    typedef logic [11:0] word;

    localparam logic DATA_READ  = 1'b0;
    localparam logic INSTR_READ = 1'b1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} arb_state_t;
    typedef enum logic {CPU, PNL} requester_t;

endpackage

// File: rtl/memory_arbiter_rr_arbiter2.sv
// Two-way round-robin winner selection; grant_o doubles as the next last_grant.
module rr_arbiter2
    import memory_utils::*;
(
    input  logic       req_cpu_i,
    input  logic       req_pnl_i,
    input  requester_t last_grant_i,
    output logic       valid_o,
    output requester_t grant_o
);

    assign valid_o = req_cpu_i | req_pnl_i;

    always_comb begin
        grant_o = PNL;
        if (req_cpu_i && req_pnl_i) begin
            grant_o = (last_grant_i == CPU) ? PNL : CPU;
        end else if (req_cpu_i) begin
            grant_o = CPU;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one memory controller between the CPU and front-panel/DMA ports with
// round-robin grants, one enable pulse per grant and a WAIT timeout.
module memory_arbiter
    import memory_utils::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic cpu_req_i,
    input  logic cpu_we_i,
    input  logic cpu_read_type_i,
    input  word  cpu_addr_i,
    input  word  cpu_wdata_i,
    output word  cpu_rdata_o,
    output logic cpu_done_o,
    output logic cpu_err_o,
    input  logic pnl_req_i,
    input  logic pnl_we_i,
    input  logic pnl_read_type_i,
    input  word  pnl_addr_i,
    input  word  pnl_wdata_i,
    output word  pnl_rdata_o,
    output logic pnl_done_o,
    output logic pnl_err_o,
    output word  mem_address_o,
    output word  mem_write_data_o,
    output logic mem_read_enable_o,
    output logic mem_write_enable_o,
    output logic mem_read_type_o,
    input  word  mem_read_data_i,
    input  logic mem_operation_done_i,
    output logic busy_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t state_q, state_d;
    requester_t grant_q, grant_d, last_grant_q, last_grant_d, arb_grant;
    logic       arb_valid;
    logic       we_q, we_d, rtype_q, rtype_d;
    word        addr_q, addr_d, wdata_q, wdata_d;
    word        cpu_rdata_q, cpu_rdata_d, pnl_rdata_q, pnl_rdata_d;
    logic       re_q, re_d, wr_q, wr_d;
    logic       cpu_done_q, cpu_done_d, cpu_err_q, cpu_err_d;
    logic       pnl_done_q, pnl_done_d, pnl_err_q, pnl_err_d;
    logic [CntW-1:0] tcnt_q, tcnt_d;
    logic       sel_we, sel_rtype, timeout;
    word        sel_addr, sel_wdata;

    rr_arbiter2 u_rr (
        .req_cpu_i   (cpu_req_i),
        .req_pnl_i   (pnl_req_i),
        .last_grant_i(last_grant_q),
        .valid_o     (arb_valid),
        .grant_o     (arb_grant)
    );

    assign sel_we    = (arb_grant == CPU) ? cpu_we_i        : pnl_we_i;
    assign sel_rtype = (arb_grant == CPU) ? cpu_read_type_i : pnl_read_type_i;
    assign sel_addr  = (arb_grant == CPU) ? cpu_addr_i      : pnl_addr_i;
    assign sel_wdata = (arb_grant == CPU) ? cpu_wdata_i     : pnl_wdata_i;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        rtype_d      = rtype_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        tcnt_d       = tcnt_q;
        cpu_rdata_d  = cpu_rdata_q;
        pnl_rdata_d  = pnl_rdata_q;
        re_d         = 1'b0;
        wr_d         = 1'b0;
        cpu_done_d   = 1'b0;
        cpu_err_d    = 1'b0;
        pnl_done_d   = 1'b0;
        pnl_err_d    = 1'b0;
        timeout      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d      = ISSUE;
                    grant_d      = arb_grant;
                    last_grant_d = arb_grant;
                    we_d         = sel_we;
                    addr_d       = sel_addr;
                    wdata_d      = sel_wdata;
                    if (!sel_we) rtype_d = sel_rtype;
                    // Enables are registered so they are high exactly during ISSUE.
                    wr_d         = sel_we;
                    re_d         = !sel_we;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                tcnt_d  = '0;
            end
            WAIT: begin
                if (mem_operation_done_i || tcnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = RESPOND;
                    timeout = !mem_operation_done_i;
                    if (grant_q == CPU) begin
                        cpu_done_d = 1'b1;
                        cpu_err_d  = timeout;
                        if (!timeout && !we_q) cpu_rdata_d = mem_read_data_i;
                    end else begin
                        pnl_done_d = 1'b1;
                        pnl_err_d  = timeout;
                        if (!timeout && !we_q) pnl_rdata_d = mem_read_data_i;
                    end
                end else begin
                    tcnt_d = tcnt_q + CntW'(1);
                end
            end
            RESPOND: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            grant_q      <= CPU;
            last_grant_q <= PNL;
            we_q         <= 1'b0;
            rtype_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            tcnt_q       <= '0;
            cpu_rdata_q  <= '0;
            pnl_rdata_q  <= '0;
            re_q         <= 1'b0;
            wr_q         <= 1'b0;
            cpu_done_q   <= 1'b0;
            cpu_err_q    <= 1'b0;
            pnl_done_q   <= 1'b0;
            pnl_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            rtype_q      <= rtype_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            tcnt_q       <= tcnt_d;
            cpu_rdata_q  <= cpu_rdata_d;
            pnl_rdata_q  <= pnl_rdata_d;
            re_q         <= re_d;
            wr_q         <= wr_d;
            cpu_done_q   <= cpu_done_d;
            cpu_err_q    <= cpu_err_d;
            pnl_done_q   <= pnl_done_d;
            pnl_err_q    <= pnl_err_d;
        end
    end

    assign cpu_rdata_o        = cpu_rdata_q;
    assign cpu_done_o         = cpu_done_q;
    assign cpu_err_o          = cpu_err_q;
    assign pnl_rdata_o        = pnl_rdata_q;
    assign pnl_done_o         = pnl_done_q;
    assign pnl_err_o          = pnl_err_q;
    assign mem_address_o      = addr_q;
    assign mem_write_data_o   = wdata_q;
    assign mem_read_enable_o  = re_q;
    assign mem_write_enable_o = wr_q;
    assign mem_read_type_o    = rtype_q;
    assign busy_o             = (state_q != IDLE);

endmodule
